// File: rtl/mux_scan_ctrl.sv
// Select sequencer for a 4:1 mux: walks sel over the enabled channels, waits SETTLE
// cycles per channel, captures f_in into data[sel] and reports per-scan change flags.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] mask,
    input  logic       f_in,
    output logic [1:0] sel,
    output logic       busy,
    output logic       done,
    output logic [3:0] data,
    output logic [3:0] changed
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] scan_mask_q, scan_mask_d;
    logic [3:0] prev_q, prev_d;
    logic [3:0] data_q, data_d;
    logic [3:0] changed_q, changed_d;

    logic [1:0] first_idx, next_idx;
    logic       has_next;
    logic       sample;

    // Lowest enabled channel of the incoming mask, and the next enabled one above sel.
    always_comb begin
        first_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) first_idx = 2'(i);
        end
    end

    always_comb begin
        has_next = 1'b0;
        next_idx = sel_q;
        for (int i = 3; i >= 0; i--) begin
            if (scan_mask_q[i] && (i > int'(sel_q))) begin
                has_next = 1'b1;
                next_idx = 2'(i);
            end
        end
    end

    assign sample = (state_q == WAIT) && (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (mask != 4'd0) ? WAIT : DONE;
            WAIT:    if (sample && !has_next) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the state register only
    always_comb begin
        busy = (state_q == WAIT);
        done = (state_q == DONE);
    end

    always_comb begin
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        scan_mask_d = scan_mask_q;
        prev_d      = prev_q;
        data_d      = data_q;
        changed_d   = changed_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (mask != 4'd0) begin
                        scan_mask_d = mask;
                        prev_d      = data_q;
                        sel_d       = first_idx;
                        cnt_d       = 4'd0;
                    end else begin
                        changed_d = 4'd0;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (sample) begin
                    data_d[sel_q] = f_in;
                    if (has_next) begin
                        sel_d = next_idx;
                        cnt_d = 4'd0;
                    end else begin
                        // Flags use the data including this final sample.
                        changed_d = scan_mask_q & (data_d ^ prev_q);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q       <= 2'd0;
            cnt_q       <= 4'd0;
            scan_mask_q <= 4'd0;
            prev_q      <= 4'd0;
            data_q      <= 4'd0;
            changed_q   <= 4'd0;
        end else begin
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            scan_mask_q <= scan_mask_d;
            prev_q      <= prev_d;
            data_q      <= data_d;
            changed_q   <= changed_d;
        end
    end

    assign sel     = sel_q;
    assign data    = data_q;
    assign changed = changed_q;

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Select sequencer and capture stage for the 4:1 multiplexer (inputs a/b/c/d, selects x/y, output f). On a start request it walks the 2-bit select through every channel enabled in a mask. After each select change it waits a programmable settle time, samples the mux output into a per-channel result register, and flags which channels changed since the previous scan. It sits on both sides of the mux: `sel` drives the mux select lines, and `f_in` consumes the mux output.

## Interface
- `SETTLE`, default 2: cycles `sel` is held before `f_in` is sampled; legal range 1..15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: scan request; sampled only in IDLE.
- `mask` in 4: channel enable; bit i enables channel i (0=a, 1=b, 2=c, 3=d). Latched at start.
- `f_in` in 1: mux output f; already synchronous to `clk`.
- `sel` out 2: mux select; `sel[1]`=y, `sel[0]`=x.
- `busy` out 1: high while a scan is in progress.
- `done` out 1: one-cycle pulse at scan completion.
- `data` out 4: last sampled value per channel; bit i = channel i.
- `changed` out 4: per-channel change flags from the most recent completed scan.

## Operation
- State machine with three states: IDLE, WAIT, DONE.
- IDLE:
  - busy=0. `sel` holds its last value.
  - If start=1 and mask≠0: latch mask into `scan_mask`, snapshot `data` into `prev_data`, load `sel` with the lowest set bit index of mask, clear the settle counter, go to WAIT.
  - If start=1 and mask=0: go to DONE with no sampling. In this case `changed` is set to 0000.
- WAIT:
  - busy=1. The counter increments each cycle.
  - On the edge that ends the SETTLE-th cycle with the current `sel`, the sample edge fires: data[sel] <= f_in.
  - If `scan_mask` has a set bit above `sel`: `sel` moves to the next set bit, the counter clears, the state stays WAIT.
  - Otherwise: go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then the state returns to IDLE.
  - `changed` is registered on the edge entering DONE: changed[i] = scan_mask[i] & (data[i] ^ prev_data[i]), using the post-sample data.
  - `changed` holds until the next DONE.
- Unscanned channels keep their previous `data` value. Their `changed` bit is 0.
- The mask is latched at start. Changes to mask during a scan have no effect.
- `start` is ignored in WAIT and DONE. Requests are not queued. A start held high across DONE begins a new scan on the first IDLE cycle.
- The counter width is sufficient for SETTLE up to 15; 4 bits.

## Timing
- Reset values:
  - State: IDLE.
  - sel=00, busy=0, done=0.
  - data=0000, changed=0000.
  - Internal `scan_mask`, `prev_data` and counter all 0.
- Let E0 be the edge at which start is accepted and N = popcount(mask).
  - `sel` is valid for the first channel from E0.
  - Sample edges fall at E0+k·SETTLE, for k = 1..N.
  - done is high in the cycle after E0+N·SETTLE. Total latency from start to done is N·SETTLE+1 edges.
  - busy is high from E0 to E0+N·SETTLE.
  - With mask=0, done is high in the cycle after E0 and busy never rises.
- `f_in` must be stable during the last settle cycle. Only the value present at the sample edge is captured.
- Asserting rst_n low mid-scan immediately forces all reset values. No done pulse is produced. The partial data is discarded and data reads 0000.
- Outputs are registered; there is no combinational path from an input to an output.

## Test plan
- Reset and full scan:
  - Stimulus: reset, then SETTLE=2, mask=1111, mux inputs a=1, b=0, c=1, d=1, start at E0.
  - Response: sel = 0, 1, 2, 3, each held 2 cycles. data=1101. done pulses once, in the cycle after E0+8. changed=1101.
- Sparse mask:
  - Stimulus: after the full scan, set d=0 and scan with mask=1010.
  - Response: sel visits only 1, then 3. data=0101. changed=1000. Channels 0 and 2 are unchanged. done occurs after E0+4.
- Empty mask:
  - Stimulus: start with mask=0000.
  - Response: busy stays 0. done pulses in the cycle after E0. data is unchanged. changed=0000.
- Ignored inputs:
  - Stimulus: while busy, pulse start and change mask to 0001.
  - Response: the scan completes with the original mask. Exactly one done pulse is produced.
- Reset mid-scan:
  - Stimulus: drop rst_n after the second sample edge of a 1111 scan.
  - Response: sel=00, busy=0, data=0000. No done pulse.
- Settle boundary:
  - Stimulus: SETTLE=1; toggle f_in one cycle before a sample edge, then again right after it.
  - Response: data captures the value present at the sample edge, not the later toggle.
